// File: rtl/sevenseg_scan_axi.sv
// rtl/sevenseg_scan_axi.sv - multiplexed seven-segment scanner fed by a one-frame-per-beat stream
module sevenseg_scan_axi #(
    parameter int N_DIGITS       = 2,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_DIGITS-1:0][6:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [6:0]               seg,
    output logic [N_DIGITS-1:0]      an,
    output logic                     frame_tick
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_next;
    logic [DW-1:0]             digit;
    logic [DW-1:0]             digit_next;
    logic [N_DIGITS-1:0][6:0]  pend;
    logic [N_DIGITS-1:0][6:0]  disp;
    logic                      pend_full;
    logic                      slot_end;
    logic                      handshake;
    logic                      commit;
    logic [6:0]                code;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= BLANK;
        end else begin
            state <= state_next;
        end
    end

    // State is computed one cycle ahead from cnt_next so seg/an decode purely from flops.
    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        cnt_next   = slot_end ? '0 : cnt + 1'b1;
        digit_next = digit;
        if (slot_end) begin
            digit_next = (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
        end
        state_next = (cnt_next < BLANK_END) ? BLANK : DRIVE;

        an   = '1;
        seg  = SEG_OFF;
        code = disp[digit];
        if (state == DRIVE) begin
            an[digit] = 1'b0;
            seg       = (SEG_ACTIVE_LOW != 0) ? ~code : code;
        end
    end

    assign frame_tick = slot_end && (digit == DIGIT_LAST);
    assign s_ready    = ~pend_full;
    assign handshake  = s_valid && !pend_full;
    assign commit     = frame_tick && pend_full;

    // Handshake and commit are mutually exclusive: one needs pend_full low, the other high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            digit     <= '0;
            pend      <= '0;
            disp      <= '0;
            pend_full <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            digit <= digit_next;
            if (handshake) begin
                pend      <= s_data;
                pend_full <= 1'b1;
            end else if (commit) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end
        end
    end

endmodule
